// File: rtl/cpu_pkg.sv
// Shared CPU core definitions: IDU opcodes, default register-pair map, flag bit positions.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDU_NONE   = 2'd0,
        IDU_INC    = 2'd1,
        IDU_DEC    = 2'd2,
        IDU_INC_NW = 2'd3
    } idu_op_e;

    localparam int PAIR_BC = 0;
    localparam int PAIR_DE = 1;
    localparam int PAIR_HL = 2;
    localparam int PAIR_FA = 3;
    localparam int PAIR_SP = 4;
    localparam int PAIR_WZ = 5;
    localparam int PAIR_PC = 6;

    localparam int FLAG_Z = 7;
    localparam int FLAG_N = 6;
    localparam int FLAG_H = 5;
    localparam int FLAG_C = 4;

    // Only real inc/dec results are allowed back into a pair.
    function automatic logic idu_writes_back(idu_op_e op);
        return (op == IDU_INC) || (op == IDU_DEC);
    endfunction

endpackage

// File: rtl/cpu_regfile_if.sv
// Sequencer <-> register file bus: read ports, byte/pair/PC/flag write controls, IDU and status outputs.
interface cpu_regfile_if #(
    parameter int NUM_PAIRS  = 7,
    parameter int READ_PORTS = 2
);
    localparam int IW = $clog2(2 * NUM_PAIRS);
    localparam int PW = $clog2(NUM_PAIRS);

    logic                     commit;
    logic [READ_PORTS*IW-1:0] rd_idx;
    logic [READ_PORTS*8-1:0]  rd_data;
    logic                     wa_en;
    logic [IW-1:0]            wa_idx;
    logic [7:0]               wa_data;
    logic                     wb_en;
    logic [IW-1:0]            wb_idx;
    logic [7:0]               wb_data;
    logic [1:0]               idu_op;
    logic [PW-1:0]            idu_pair;
    logic                     idu_ovr_en;
    logic [15:0]              idu_ovr;
    logic                     idu_wr;
    logic                     pc_wr;
    logic                     flag_wr;
    logic [3:0]               flag_data;
    logic [15:0]              idu_in;
    logic [15:0]              idu_out;
    logic [15:0]              pc;
    logic [3:0]               flags;

    modport master (
        output commit, rd_idx, wa_en, wa_idx, wa_data, wb_en, wb_idx, wb_data,
               idu_op, idu_pair, idu_ovr_en, idu_ovr, idu_wr, pc_wr, flag_wr, flag_data,
        input  rd_data, idu_in, idu_out, pc, flags
    );

    modport slave (
        input  commit, rd_idx, wa_en, wa_idx, wa_data, wb_en, wb_idx, wb_data,
               idu_op, idu_pair, idu_ovr_en, idu_ovr, idu_wr, pc_wr, flag_wr, flag_data,
        output rd_data, idu_in, idu_out, pc, flags
    );

endinterface

// File: rtl/cpu_idu.sv
// 16-bit increment/decrement/pass unit, purely combinational, wraps modulo 2^16.
module cpu_idu
    import cpu_pkg::*;
(
    input  idu_op_e     op,
    input  logic [15:0] din,
    output logic [15:0] dout
);

    always_comb begin
        case (op)
            IDU_INC, IDU_INC_NW: dout = din + 16'd1;
            IDU_DEC:             dout = din - 16'd1;
            default:             dout = din;
        endcase
    end

endmodule

// File: rtl/cpu_regfile.sv
// SM83-style byte register file with pair-wide IDU write-back, PC and flag paths, optional bypass.
// All state changes on a commit-qualified clock edge; reads and IDU are zero-latency.
module cpu_regfile
    import cpu_pkg::*;
#(
    parameter int          NUM_PAIRS  = 7,
    parameter int          READ_PORTS = 2,
    parameter int          BYPASS     = 0,
    parameter int          PC_PAIR    = PAIR_PC,
    parameter int          FLAG_REG   = 6,
    parameter logic [15:0] RESET_PC   = 16'h0000
) (
    input  logic           clk,
    input  logic           reset,
    cpu_regfile_if.slave   bus
);

    localparam int NB = 2 * NUM_PAIRS;
    localparam int IW = $clog2(NB);
    localparam int NP = 2 ** IW;

    logic [7:0]    regs     [NB];
    logic [7:0]    nxt      [NB];
    logic [7:0]    regs_pad [NP];
    logic [7:0]    view_pad [NP];
    logic [IW-1:0] pair_hi;
    logic [IW-1:0] pair_lo;
    logic          idu_we;
    idu_op_e       op;

    assign op      = idu_op_e'(bus.idu_op);
    assign pair_hi = IW'({bus.idu_pair, 1'b0});
    assign pair_lo = pair_hi | IW'(1);
    assign idu_we  = bus.idu_wr && idu_writes_back(op);

    // Padding to a power of two makes out-of-range indices read as zero.
    always_comb begin
        for (int i = 0; i < NP; i++) regs_pad[i] = 8'h00;
        for (int i = 0; i < NB; i++) regs_pad[i] = regs[i];
    end

    // IDU input always comes from stored state, never from the bypass path.
    assign bus.idu_in = bus.idu_ovr_en ? bus.idu_ovr : {regs_pad[pair_hi], regs_pad[pair_lo]};

    cpu_idu u_idu (
        .op   (op),
        .din  (bus.idu_in),
        .dout (bus.idu_out)
    );

    // Writes applied lowest priority first so later ones win on colliding bytes.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            nxt[i] = regs[i];
            if (bus.wa_en && bus.wa_idx == IW'(i)) nxt[i] = bus.wa_data;
            if (bus.wb_en && bus.wb_idx == IW'(i)) nxt[i] = bus.wb_data;
            if (idu_we && pair_hi == IW'(i))       nxt[i] = bus.idu_out[15:8];
            if (idu_we && pair_lo == IW'(i))       nxt[i] = bus.idu_out[7:0];
            if (bus.pc_wr && i == 2 * PC_PAIR)     nxt[i] = bus.idu_out[15:8];
            if (bus.pc_wr && i == 2 * PC_PAIR + 1) nxt[i] = bus.idu_out[7:0];
            if (i == FLAG_REG) begin
                if (bus.flag_wr) nxt[i][7:4] = bus.flag_data;
                nxt[i][3:0] = 4'h0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NB; i++) regs[i] <= 8'h00;
            regs[2*PC_PAIR]   <= RESET_PC[15:8];
            regs[2*PC_PAIR+1] <= RESET_PC[7:0];
        end else if (bus.commit) begin
            for (int i = 0; i < NB; i++) regs[i] <= nxt[i];
        end
    end

    always_comb begin
        for (int i = 0; i < NP; i++) view_pad[i] = 8'h00;
        for (int i = 0; i < NB; i++) view_pad[i] = (BYPASS != 0 && bus.commit) ? nxt[i] : regs[i];
    end

    always_comb begin
        bus.rd_data = '0;
        for (int k = 0; k < READ_PORTS; k++)
            bus.rd_data[k*8 +: 8] = view_pad[bus.rd_idx[k*IW +: IW]];
    end

    assign bus.pc    = {view_pad[2*PC_PAIR], view_pad[2*PC_PAIR+1]};
    assign bus.flags = view_pad[FLAG_REG][FLAG_Z:FLAG_C];

endmodule

// File: tb/tb_cpu_regfile.sv
// Directed bench: two register files (no-bypass with RESET_PC=0100, bypass with RESET_PC=0000) on shared stimulus.
module tb_cpu_regfile;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    cpu_regfile_if #(.NUM_PAIRS(7), .READ_PORTS(2)) bus0 ();
    cpu_regfile_if #(.NUM_PAIRS(7), .READ_PORTS(2)) bus1 ();

    assign bus1.commit     = bus0.commit;
    assign bus1.rd_idx     = bus0.rd_idx;
    assign bus1.wa_en      = bus0.wa_en;
    assign bus1.wa_idx     = bus0.wa_idx;
    assign bus1.wa_data    = bus0.wa_data;
    assign bus1.wb_en      = bus0.wb_en;
    assign bus1.wb_idx     = bus0.wb_idx;
    assign bus1.wb_data    = bus0.wb_data;
    assign bus1.idu_op     = bus0.idu_op;
    assign bus1.idu_pair   = bus0.idu_pair;
    assign bus1.idu_ovr_en = bus0.idu_ovr_en;
    assign bus1.idu_ovr    = bus0.idu_ovr;
    assign bus1.idu_wr     = bus0.idu_wr;
    assign bus1.pc_wr      = bus0.pc_wr;
    assign bus1.flag_wr    = bus0.flag_wr;
    assign bus1.flag_data  = bus0.flag_data;

    cpu_regfile #(.BYPASS(0), .RESET_PC(16'h0100)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus0)
    );

    cpu_regfile #(.BYPASS(1), .RESET_PC(16'h0000)) u_dut1 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus0.commit     = 1'b0;
        bus0.wa_en      = 1'b0;
        bus0.wa_idx     = '0;
        bus0.wa_data    = '0;
        bus0.wb_en      = 1'b0;
        bus0.wb_idx     = '0;
        bus0.wb_data    = '0;
        bus0.idu_op     = IDU_NONE;
        bus0.idu_pair   = '0;
        bus0.idu_ovr_en = 1'b0;
        bus0.idu_ovr    = '0;
        bus0.idu_wr     = 1'b0;
        bus0.pc_wr      = 1'b0;
        bus0.flag_wr    = 1'b0;
        bus0.flag_data  = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p0, input int p1);
        bus0.rd_idx = {4'(p1), 4'(p0)};
        #1;
    endtask

    // Port 0 of the non-bypass file reads one byte.
    task automatic chk_reg(input string tag, input int idx, input logic [7:0] exp);
        set_rd(idx, idx);
        chk(tag, {24'h0, bus0.rd_data[7:0]}, {24'h0, exp});
    endtask

    initial begin
        idle();
        bus0.rd_idx = '0;
        reset = 1'b1;
        step();
        chk("rst_pc", {16'h0, bus0.pc}, 32'h0100);
        chk("rst_flags", {28'h0, bus0.flags}, 32'h0);
        for (int i = 0; i < 12; i++) chk_reg($sformatf("rst_byte%0d", i), i, 8'h00);
        chk_reg("rst_pc_hi", 12, 8'h01);
        chk_reg("rst_pc_lo", 13, 8'h00);
        chk("rst_pc_dut1", {16'h0, bus1.pc}, 32'h0000);
        reset = 1'b0;

        // Byte write to the flag register drops the low nibble.
        bus0.wa_en = 1'b1; bus0.wa_idx = 4'd6; bus0.wa_data = 8'h5A; bus0.commit = 1'b1;
        step(); idle();
        chk_reg("flag_byte", 6, 8'h50);
        chk("flag_out", {28'h0, bus0.flags}, 32'h5);

        // HL = FFFF, then inc wraps to 0000.
        bus0.wa_en = 1'b1; bus0.wa_idx = 4'd4; bus0.wa_data = 8'hFF;
        bus0.wb_en = 1'b1; bus0.wb_idx = 4'd5; bus0.wb_data = 8'hFF; bus0.commit = 1'b1;
        step(); idle();
        bus0.idu_op = IDU_INC; bus0.idu_pair = 3'(PAIR_HL); bus0.idu_wr = 1'b1; bus0.commit = 1'b1;
        #1;
        chk("inc_idu_in", {16'h0, bus0.idu_in}, 32'hFFFF);
        chk("inc_idu_out", {16'h0, bus0.idu_out}, 32'h0000);
        step(); idle();
        chk_reg("inc_h", 4, 8'h00);
        chk_reg("inc_l", 5, 8'h00);

        // Op 3 computes +1 but never writes back.
        bus0.idu_op = IDU_INC_NW; bus0.idu_pair = 3'(PAIR_HL); bus0.idu_wr = 1'b1; bus0.commit = 1'b1;
        #1;
        chk("nw_idu_out", {16'h0, bus0.idu_out}, 32'h0001);
        step(); idle();
        chk_reg("nw_h", 4, 8'h00);
        chk_reg("nw_l", 5, 8'h00);

        bus0.idu_op = IDU_DEC; bus0.idu_pair = 3'(PAIR_HL); bus0.idu_wr = 1'b1; bus0.commit = 1'b1;
        #1;
        chk("dec_idu_out", {16'h0, bus0.idu_out}, 32'hFFFF);
        step(); idle();
        chk_reg("dec_h", 4, 8'hFF);
        chk_reg("dec_l", 5, 8'hFF);

        // Collision: IDU pair write beats ports B and A on C; B byte comes from IDU.
        bus0.wa_en = 1'b1; bus0.wa_idx = 4'd1; bus0.wa_data = 8'h11;
        bus0.wb_en = 1'b1; bus0.wb_idx = 4'd1; bus0.wb_data = 8'h22;
        bus0.idu_ovr_en = 1'b1; bus0.idu_ovr = 16'h3343; bus0.idu_op = IDU_INC;
        bus0.idu_pair = 3'(PAIR_BC); bus0.idu_wr = 1'b1; bus0.commit = 1'b1;
        step(); idle();
        set_rd(0, 1);
        chk("coll_b", {24'h0, bus0.rd_data[7:0]}, 32'h33);
        chk("coll_c", {24'h0, bus0.rd_data[15:8]}, 32'h44);

        bus0.wa_en = 1'b1; bus0.wa_idx = 4'd1; bus0.wa_data = 8'h11;
        bus0.wb_en = 1'b1; bus0.wb_idx = 4'd1; bus0.wb_data = 8'h22; bus0.commit = 1'b1;
        step(); idle();
        chk_reg("coll_noidu_c", 1, 8'h22);
        chk_reg("coll_noidu_b", 0, 8'h33);

        // flag_wr beats port A on F; port B to A lands untouched.
        bus0.flag_wr = 1'b1; bus0.flag_data = 4'hA;
        bus0.wa_en = 1'b1; bus0.wa_idx = 4'd6; bus0.wa_data = 8'hFF;
        bus0.wb_en = 1'b1; bus0.wb_idx = 4'd7; bus0.wb_data = 8'h3C; bus0.commit = 1'b1;
        step(); idle();
        chk_reg("flagprio_f", 6, 8'hA0);
        chk_reg("flagprio_a", 7, 8'h3C);
        chk("flagprio_flags", {28'h0, bus0.flags}, 32'hA);

        bus0.idu_ovr_en = 1'b1; bus0.idu_ovr = 16'h12FE; bus0.pc_wr = 1'b1; bus0.commit = 1'b1;
        #1;
        chk("pcwr_idu_out", {16'h0, bus0.idu_out}, 32'h12FE);
        step(); idle();
        chk("pcwr_pc", {16'h0, bus0.pc}, 32'h12FE);

        // Every enable high but commit low: nothing moves.
        bus0.wa_en = 1'b1; bus0.wa_idx = 4'd0; bus0.wa_data = 8'hEE;
        bus0.wb_en = 1'b1; bus0.wb_idx = 4'd1; bus0.wb_data = 8'hEE;
        bus0.idu_op = IDU_INC; bus0.idu_pair = 3'(PAIR_BC); bus0.idu_wr = 1'b1;
        bus0.pc_wr = 1'b1; bus0.flag_wr = 1'b1; bus0.flag_data = 4'hF; bus0.commit = 1'b0;
        step(); idle();
        chk("nocommit_pc", {16'h0, bus0.pc}, 32'h12FE);
        chk_reg("nocommit_b", 0, 8'h33);
        chk_reg("nocommit_c", 1, 8'h22);
        chk("nocommit_flags", {28'h0, bus0.flags}, 32'hA);

        // Bypass file shows the in-flight value; plain file shows the old one.
        bus0.wb_en = 1'b1; bus0.wb_idx = 4'd7; bus0.wb_data = 8'h9C;
        bus0.flag_wr = 1'b1; bus0.flag_data = 4'h3; bus0.commit = 1'b1;
        set_rd(7, 7);
        chk("byp_rd_dut1", {24'h0, bus1.rd_data[7:0]}, 32'h9C);
        chk("byp_rd1_dut1", {24'h0, bus1.rd_data[15:8]}, 32'h9C);
        chk("byp_flags_dut1", {28'h0, bus1.flags}, 32'h3);
        chk("nobyp_rd_dut0", {24'h0, bus0.rd_data[7:0]}, 32'h3C);
        chk("nobyp_flags_dut0", {28'h0, bus0.flags}, 32'hA);
        step(); idle();
        chk_reg("nobyp_after", 7, 8'h9C);
        chk("nobyp_flags_after", {28'h0, bus0.flags}, 32'h3);

        // Reset overrides a concurrent commit.
        reset = 1'b1;
        bus0.wa_en = 1'b1; bus0.wa_idx = 4'd0; bus0.wa_data = 8'h55; bus0.commit = 1'b1;
        step(); idle();
        reset = 1'b0;
        chk_reg("midrst_b", 0, 8'h00);
        chk_reg("midrst_a", 7, 8'h00);
        chk("midrst_pc", {16'h0, bus0.pc}, 32'h0100);
        chk("midrst_flags", {28'h0, bus0.flags}, 32'h0);

        // Out-of-range write indices are ignored and read back as zero.
        bus0.wa_en = 1'b1; bus0.wa_idx = 4'd14; bus0.wa_data = 8'h77;
        bus0.wb_en = 1'b1; bus0.wb_idx = 4'd15; bus0.wb_data = 8'h66; bus0.commit = 1'b1;
        step(); idle();
        set_rd(14, 15);
        chk("oor_rd14", {24'h0, bus0.rd_data[7:0]}, 32'h00);
        chk("oor_rd15", {24'h0, bus0.rd_data[15:8]}, 32'h00);
        chk("oor_pc", {16'h0, bus0.pc}, 32'h0100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
